dadda_prod_accum: RTL and testbench

- Sequential accumulator directly downstream of the 8x8 Dadda multiplier.
- Consumes the 16-bit unsigned product stream over a valid/ready handshake and sums a programmed number of products into a wide accumulator.
- Presents the total on a registered valid/ready output port.
- Turns the combinational multiplier into a dot-product / MAC datapath.

---
 rtl/dadda_prod_accum.sv | 93 +++++++++
 tb/tb_dadda_prod_accum.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dadda_prod_accum.sv
// Accumulates a programmed number of 16-bit unsigned products into an ACC_W-bit sum and returns it over valid/ready.
// Latency is 1 cycle from the last accepted beat to out_valid. The result is held while out_ready is low. Macro DADDA_ACCUM_SAT_EN selects a saturating add.
module dadda_prod_accum #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             beat;
    logic [ACC_W:0]   sum_ext;

    assign beat    = in_valid && in_ready;
    assign sum_ext = {1'b0, acc} + {{(ACC_W-15){1'b0}}, in_prod};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len == '0) ? DONE : ACCUM;
            ACCUM:   if (beat && cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs: handshakes depend on state only.
    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // acc/ovf persist after the handshake, so the last result stays on out_sum until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        ovf <= 1'b0;
                        cnt <= len;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        cnt <= cnt - CNT_W'(1);
                        ovf <= ovf | sum_ext[ACC_W];
`ifdef DADDA_ACCUM_SAT_EN
                        acc <= sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
                        acc <= sum_ext[ACC_W-1:0];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_sum = acc;
    assign out_ovf = ovf;

endmodule

// File: tb/tb_dadda_prod_accum.sv
// Directed plus randomized bench for dadda_prod_accum: a 24-bit and a 16-bit instance share stimulus and are checked against a plain-arithmetic model.
module tb_dadda_prod_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [15:0] in_prod;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_ovf,  busy;
    logic [23:0] out_sum;
    logic        in_ready16, out_valid16, out_ovf16, busy16;
    logic [15:0] out_sum16;

    int n_cmp = 0;
    int n_err = 0;
    int unsigned prods[$];

    always #5 clk = ~clk;

    dadda_prod_accum #(.ACC_W(24), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy)
    );

    dadda_prod_accum #(.ACC_W(16), .CNT_W(8)) u_dut16 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready16), .in_prod(in_prod),
        .out_valid(out_valid16), .out_ready(out_ready),
        .out_sum(out_sum16), .out_ovf(out_ovf16), .busy(busy16)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: true sum of all terms, reduced to the result width.
    function automatic longint model_sum(input int w, input longint total);
        longint lim = longint'(1) << w;
`ifdef DADDA_ACCUM_SAT_EN
        if (total >= lim) return lim - 1;
`endif
        return total % lim;
    endfunction

    function automatic longint model_ovf(input int w, input longint total);
        return (total >= (longint'(1) << w)) ? 1 : 0;
    endfunction

    task automatic run_job(input int n, input int gap_pct, input int rdy_dly, input bit poke);
        longint total = 0;
        int idx = 0;
        int guard = 0;
        foreach (prods[i]) total += prods[i];
        start = 1'b1;
        len   = n[7:0];
        step();
        start = 1'b0;
        len   = 8'd0;
        check("busy_after_start", busy, 1);
        if (n > 0) check("in_ready_accum", in_ready, 1);
        while (idx < n && guard < 2000) begin
            start = (poke && idx == 1);
            len   = poke ? 8'd9 : 8'd0;
            if (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                in_prod  = 16'($urandom);
            end else begin
                in_valid = 1'b1;
                in_prod  = 16'(prods[idx]);
            end
            if (in_valid && in_ready) idx++;
            step();
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        len      = 8'd0;
        check("beats_accepted", idx, n);
        check("out_valid_done", out_valid, 1);
        check("in_ready_done", in_ready, 0);
        check("out_sum", out_sum, model_sum(24, total));
        check("out_ovf", out_ovf, model_ovf(24, total));
        check("out_sum16", out_sum16, model_sum(16, total));
        check("out_ovf16", out_ovf16, model_ovf(16, total));
        for (int k = 0; k < rdy_dly; k++) begin
            start = poke;
            len   = 8'd9;
            step();
            check("hold_valid", out_valid, 1);
            check("hold_sum", out_sum, model_sum(24, total));
            check("hold_ovf16", out_ovf16, model_ovf(16, total));
        end
        out_ready = 1'b1;
        start     = poke;
        len       = 8'd9;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        len       = 8'd0;
        check("idle_valid", out_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_keeps_sum", out_sum, model_sum(24, total));
        if (poke) begin
            step();
            check("start_on_handshake_ignored", busy, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0; in_prod = 16'd0; out_ready = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_ovf", out_ovf, 0);
        @(posedge clk); #1 rst = 1'b0;
        step();

        // Basic run, back-to-back, immediate acceptance
        prods = '{32'h0001, 32'h00FF, 32'hFE01};
        run_job(3, 0, 0, 1'b0);

        // Gaps and 5 cycles of backpressure
        prods = '{32'h1000, 32'h2000};
        run_job(2, 50, 5, 1'b0);

        // Zero length: straight to DONE with a zero result
        prods = {};
        run_job(0, 0, 2, 1'b0);

        // Carry out of the narrow instance
        prods = '{32'hFFFF, 32'h0002};
        run_job(2, 0, 1, 1'b0);

        // Asynchronous reset between edges mid-run
        start = 1'b1; len = 8'd4; step();
        start = 1'b0; len = 8'd0;
        in_valid = 1'b1; in_prod = 16'h0007; step();
        in_prod = 16'h0009; step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out_sum", out_sum, 0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_idle", busy, 0);
        prods = '{32'h0005};
        run_job(1, 0, 0, 1'b0);

        // start pulses during ACCUM, DONE and the handshake cycle are ignored
        prods = '{32'h0123, 32'h0456};
        run_job(2, 30, 3, 1'b1);

        // Randomized runs
        for (int r = 0; r < 20; r++) begin
            int n = int'($urandom_range(1, 12));
            prods = {};
            for (int j = 0; j < n; j++) prods.push_back($urandom_range(0, 65535));
            run_job(n, int'($urandom_range(0, 60)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        // Maximum length, maximum products
        prods = {};
        for (int j = 0; j < 255; j++) prods.push_back(32'hFFFF);
        run_job(255, 10, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
